// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit: sequencer states,
// opcode encodings and the position of the opcode field in an instruction word.
package ifu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    CAP_I,
    RD_IMM,
    CAP_IMM,
    ISSUE,
    EXEC,
    STOP
  } state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OPC_HI = 8;
  localparam int OPC_LO = 6;

endpackage

// File: rtl/ifu_timeout_ctr.sv
// Watchdog counter for the Done handshake: cleared when an instruction is issued,
// counts while waiting, and flags terminal count when it reaches TIMEOUT.
module ifu_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic Resetn,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!Resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(TIMEOUT));

endmodule

// File: rtl/instr_fetch_unit.sv
// Program sequencer feeding the control-unit processor: fetches instruction and
// immediate words, pulses Run, and waits (with a watchdog) for Done.
module instr_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              Enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] DinOut,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              err
);

  import ifu_pkg::*;

  state_t            state;
  logic [DATA_W-1:0] ir_word;
  logic [DATA_W-1:0] imm_word;
  logic              is_mvi;
  logic [2:0]        opc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic              tmr_clear;
  logic              tmr_en;
  logic              tmr_tc;

  assign opc     = mem_data[OPC_HI:OPC_LO];
  assign pc_inc  = pc + ADDR_W'(1);
  assign pc_next = pc + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));

  assign tmr_clear = (state == ISSUE);
  assign tmr_en    = (state == EXEC) && !Done && !tmr_tc;

  ifu_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .Resetn(Resetn),
    .clear (tmr_clear),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  // Outputs are registered: each is loaded on the edge that enters the state
  // in which it must be visible, so mem_rd/Run are high exactly in RD_*/ISSUE.
  always_ff @(posedge clk) begin
    if (!Resetn) begin
      state    <= IDLE;
      pc       <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      DinOut   <= '0;
      Run      <= 1'b0;
      halted   <= 1'b0;
      err      <= 1'b0;
      ir_word  <= '0;
      imm_word <= '0;
      is_mvi   <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      Run    <= 1'b0;
      case (state)
        IDLE: begin
          if (Enable && !halted && !err) begin
            mem_addr <= pc;
            mem_rd   <= 1'b1;
            state    <= RD_I;
          end
        end
        RD_I: state <= CAP_I;
        CAP_I: begin
          ir_word <= mem_data;
          is_mvi  <= 1'b0;
          case (opc)
            OP_HALT: begin
              halted <= 1'b1;
              state  <= STOP;
            end
            OP_MVI: begin
              is_mvi   <= 1'b1;
              mem_addr <= pc_inc;
              mem_rd   <= 1'b1;
              state    <= RD_IMM;
            end
            OP_MV, OP_ADD, OP_SUB: begin
              DinOut <= mem_data;
              Run    <= 1'b1;
              state  <= ISSUE;
            end
            default: begin
              DinOut <= mem_data;
              Run    <= 1'b1;
              state  <= ISSUE;
            end
          endcase
        end
        RD_IMM: state <= CAP_IMM;
        CAP_IMM: begin
          imm_word <= mem_data;
          DinOut   <= ir_word;
          Run      <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          // The processor reads the immediate in its T1 step, so mvi switches DinOut here.
          DinOut <= is_mvi ? imm_word : ir_word;
          state  <= EXEC;
        end
        EXEC: begin
          if (Done) begin
            pc <= pc_next;
            if (Enable) begin
              mem_addr <= pc_next;
              mem_rd   <= 1'b1;
              state    <= RD_I;
            end else begin
              state <= IDLE;
            end
          end else if (tmr_tc) begin
            err   <= 1'b1;
            state <= STOP;
          end
        end
        STOP: state <= STOP;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: behavioural program memory and processor
// models, with a scoreboard of expected issued instructions per scenario.
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              Resetn;
  logic              Enable;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] DinOut;
  logic              Run;
  logic              Done;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              err;

  typedef struct {
    logic [DATA_W-1:0] din_i;
    logic [DATA_W-1:0] din_e;
    logic [ADDR_W-1:0] pc;
    int                gap;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] mem [0:255];
  int                checks = 0;
  int                errors = 0;
  int                run_count = 0;
  int                done_delay = 0;
  int                pend = 0;
  logic [ADDR_W-1:0] last_rd_addr = '0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .Resetn  (Resetn),
    .Enable  (Enable),
    .mem_addr(mem_addr),
    .mem_rd  (mem_rd),
    .mem_data(mem_data),
    .DinOut  (DinOut),
    .Run     (Run),
    .Done    (Done),
    .pc      (pc),
    .halted  (halted),
    .err     (err)
  );

  // Synchronous program memory: data appears one cycle after a read strobe.
  initial begin : mem_model
    logic [ADDR_W-1:0] a;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (mem_rd === 1'b1) begin
        a = mem_addr;
        @(posedge clk);
        #1 mem_data = mem[a];
      end
    end
  end

  // Processor model: Done pulses done_delay cycles after Run (0 means never).
  initial begin : proc_model
    Done = 1'b0;
    forever begin
      @(negedge clk);
      Done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) Done = 1'b1;
      end
      if (Run === 1'b1 && done_delay > 0) pend = done_delay;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (Run === 1'b1) run_count++;
      if (mem_rd === 1'b1) last_rd_addr = mem_addr;
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void push_exp(input logic [DATA_W-1:0] di, input logic [DATA_W-1:0] de,
                                   input logic [ADDR_W-1:0] p, input int g);
    exp_t e;
    e.din_i = di;
    e.din_e = de;
    e.pc    = p;
    e.gap   = g;
    sb.push_back(e);
  endfunction

  task automatic wait_run(input int budget, output bit seen, output int n);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (Run === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    Resetn = 1'b0;
    Enable = 1'b0;
    repeat (2) @(negedge clk);
    Resetn = 1'b1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    Resetn = 1'b0;
    Enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pc !== 8'd0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 00", pc); end
    checks++; if (mem_addr !== 8'd0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 00", mem_addr); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    checks++; if (DinOut !== 16'h0000) begin errors++; $display("[TB] FAIL reset_dinout: got %h expected 0000", DinOut); end
    checks++; if (Run !== 1'b0) begin errors++; $display("[TB] FAIL reset_run: got %b expected 0", Run); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    Enable = 1'b0;
    Resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    bit   seen;
    int   n;
    int   r0;
    exp_t e;
    $display("[TB] test_add");
    sb.delete();
    mem[0] = 16'h0080;
    mem[1] = 16'h00C0;
    done_delay = 3;
    push_exp(16'h0080, 16'h0080, 8'd0, 0);
    push_exp(16'h00C0, 16'h00C0, 8'd1, done_delay + 3);
    r0 = run_count;
    Enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_run(60, seen, n);
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL add_run_seen: no Run in 60 cycles, expected pulse %0d", i); return; end
      e = sb.pop_front();
      checks++; if (DinOut !== e.din_i) begin errors++; $display("[TB] FAIL add_issue_din: got %h expected %h", DinOut, e.din_i); end
      checks++; if (pc !== e.pc) begin errors++; $display("[TB] FAIL add_issue_pc: got %h expected %h", pc, e.pc); end
      if (e.gap != 0) begin
        checks++; if (n + 1 != e.gap) begin errors++; $display("[TB] FAIL add_run_gap: got %0d expected %0d", n + 1, e.gap); end
      end
      if (i == 1) begin
        checks++; if (last_rd_addr !== 8'd1) begin errors++; $display("[TB] FAIL add_rd_addr: got %h expected 01", last_rd_addr); end
        Enable = 1'b0;
      end
      @(negedge clk);
      checks++; if (Run !== 1'b0) begin errors++; $display("[TB] FAIL add_run_pulse: got %b expected 0", Run); end
      checks++; if (DinOut !== e.din_e) begin errors++; $display("[TB] FAIL add_exec_din: got %h expected %h", DinOut, e.din_e); end
    end
    repeat (20) @(negedge clk);
    checks++; if (pc !== 8'd2) begin errors++; $display("[TB] FAIL add_pc_after: got %h expected 02", pc); end
    checks++; if (run_count - r0 != 2) begin errors++; $display("[TB] FAIL add_run_count: got %0d expected 2", run_count - r0); end
  endtask

  task automatic test_mvi();
    bit   seen;
    int   n;
    exp_t e;
    $display("[TB] test_mvi");
    sb.delete();
    mem[2] = 16'h0011;
    mem[3] = 16'h0080;
    mem[4] = 16'h0048;
    mem[5] = 16'h1234;
    done_delay = 1;
    push_exp(16'h0011, 16'h0011, 8'd2, 0);
    push_exp(16'h0080, 16'h0080, 8'd3, done_delay + 3);
    push_exp(16'h0048, 16'h1234, 8'd4, done_delay + 5);
    Enable = 1'b1;
    while (sb.size() > 0) begin
      wait_run(60, seen, n);
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL mvi_run_seen: no Run in 60 cycles, expected pc %h", sb[0].pc); Enable = 1'b0; return; end
      e = sb.pop_front();
      if (sb.size() == 0) Enable = 1'b0;
      checks++; if (DinOut !== e.din_i) begin errors++; $display("[TB] FAIL mvi_issue_din: got %h expected %h", DinOut, e.din_i); end
      checks++; if (pc !== e.pc) begin errors++; $display("[TB] FAIL mvi_issue_pc: got %h expected %h", pc, e.pc); end
      if (e.gap != 0) begin
        checks++; if (n + 1 != e.gap) begin errors++; $display("[TB] FAIL mvi_run_gap: got %0d expected %0d", n + 1, e.gap); end
      end
      @(negedge clk);
      checks++; if (DinOut !== e.din_e) begin errors++; $display("[TB] FAIL mvi_exec_din: got %h expected %h", DinOut, e.din_e); end
    end
    repeat (10) @(negedge clk);
    checks++; if (pc !== 8'd6) begin errors++; $display("[TB] FAIL mvi_pc_after: got %h expected 06", pc); end
  endtask

  task automatic test_wrap();
    bit         seen;
    int         n;
    exp_t       e;
    logic [7:0] av;
    $display("[TB] test_wrap");
    sb.delete();
    done_delay = 1;
    for (int a = 6; a <= 254; a++) begin
      av = a[7:0];
      mem[a] = {av[6:0], 3'b000, av[5:0]};
      push_exp(mem[a], mem[a], av, (a == 6) ? 0 : done_delay + 3);
    end
    mem[255] = 16'h0248;
    mem[0]   = 16'hBEEF;
    push_exp(16'h0248, 16'hBEEF, 8'd255, done_delay + 5);
    Enable = 1'b1;
    while (sb.size() > 0) begin
      wait_run(60, seen, n);
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL wrap_run_seen: no Run in 60 cycles, expected pc %h", sb[0].pc); Enable = 1'b0; return; end
      e = sb.pop_front();
      if (sb.size() == 0) Enable = 1'b0;
      checks++; if (DinOut !== e.din_i) begin errors++; $display("[TB] FAIL wrap_issue_din: got %h expected %h", DinOut, e.din_i); end
      checks++; if (pc !== e.pc) begin errors++; $display("[TB] FAIL wrap_issue_pc: got %h expected %h", pc, e.pc); end
      if (e.gap != 0) begin
        checks++; if (n + 1 != e.gap) begin errors++; $display("[TB] FAIL wrap_run_gap: got %0d expected %0d at pc %h", n + 1, e.gap, e.pc); end
      end
      if (e.pc == 8'd255) begin
        checks++; if (last_rd_addr !== 8'd0) begin errors++; $display("[TB] FAIL wrap_imm_addr: got %h expected 00", last_rd_addr); end
      end
      @(negedge clk);
      checks++; if (DinOut !== e.din_e) begin errors++; $display("[TB] FAIL wrap_exec_din: got %h expected %h", DinOut, e.din_e); end
    end
    repeat (10) @(negedge clk);
    checks++; if (pc !== 8'd1) begin errors++; $display("[TB] FAIL wrap_pc_after: got %h expected 01", pc); end
  endtask

  task automatic test_halt();
    int r0;
    $display("[TB] test_halt");
    mem[1] = 16'h01C0;
    r0 = run_count;
    Enable = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_flag: got %b expected 1", halted); end
    checks++; if (pc !== 8'd1) begin errors++; $display("[TB] FAIL halt_pc: got %h expected 01", pc); end
    for (int i = 0; i < 6; i++) begin
      Enable = i[0];
      repeat (3) @(negedge clk);
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_sticky: got %b expected 1", halted); end
    checks++; if (run_count != r0) begin errors++; $display("[TB] FAIL halt_no_run: got %0d pulses expected 0", run_count - r0); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL halt_no_fetch: got %b expected 0", mem_rd); end
    do_reset();
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_cleared: got %b expected 0", halted); end
  endtask

  task automatic test_timeout();
    bit seen;
    int n;
    int r0;
    $display("[TB] test_timeout");
    mem[0] = 16'h0080;
    done_delay = 0;
    r0 = run_count;
    Enable = 1'b1;
    wait_run(60, seen, n);
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL timeout_run_seen: no Run in 60 cycles, expected pulse"); Enable = 1'b0; return; end
    repeat (TIMEOUT + 1) @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early: got %b expected 0", err); end
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: got %b expected 1", err); end
    repeat (10) @(negedge clk);
    checks++; if (pc !== 8'd0) begin errors++; $display("[TB] FAIL timeout_pc: got %h expected 00", pc); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %b expected 1", err); end
    checks++; if (run_count - r0 != 1) begin errors++; $display("[TB] FAIL timeout_run_count: got %0d expected 1", run_count - r0); end
    do_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_cleared: got %b expected 0", err); end
  endtask

  task automatic test_done_at_timeout();
    bit seen;
    int n;
    $display("[TB] test_done_at_timeout");
    mem[0] = 16'h0080;
    done_delay = TIMEOUT + 1;
    Enable = 1'b1;
    wait_run(60, seen, n);
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL dto_run_seen: no Run in 60 cycles, expected pulse"); Enable = 1'b0; return; end
    Enable = 1'b0;
    repeat (TIMEOUT + 6) @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL dto_err: got %b expected 0", err); end
    checks++; if (pc !== 8'd1) begin errors++; $display("[TB] FAIL dto_pc: got %h expected 01", pc); end
  endtask

  task automatic test_reset_in_exec();
    bit seen;
    int n;
    int r0;
    $display("[TB] test_reset_in_exec");
    mem[1] = 16'h0080;
    done_delay = 5;
    Enable = 1'b1;
    wait_run(60, seen, n);
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL rexec_run_seen: no Run in 60 cycles, expected pulse"); Enable = 1'b0; return; end
    checks++; if (pc !== 8'd1) begin errors++; $display("[TB] FAIL rexec_pc_before: got %h expected 01", pc); end
    @(negedge clk);
    Resetn = 1'b0;
    Enable = 1'b0;
    @(negedge clk);
    checks++; if (Run !== 1'b0) begin errors++; $display("[TB] FAIL rexec_run: got %b expected 0", Run); end
    checks++; if (pc !== 8'd0) begin errors++; $display("[TB] FAIL rexec_pc: got %h expected 00", pc); end
    checks++; if (DinOut !== 16'h0000) begin errors++; $display("[TB] FAIL rexec_dinout: got %h expected 0000", DinOut); end
    checks++; if (halted !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL rexec_flags: got halted=%b err=%b expected 0 0", halted, err); end
    Resetn = 1'b1;
    r0 = run_count;
    repeat (10) @(negedge clk);
    checks++; if (pc !== 8'd0) begin errors++; $display("[TB] FAIL rexec_done_ignored: got pc %h expected 00", pc); end
    checks++; if (run_count != r0) begin errors++; $display("[TB] FAIL rexec_no_run: got %0d pulses expected 0", run_count - r0); end
  endtask

  initial begin
    Resetn = 1'b0;
    Enable = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_add();
    test_mvi();
    test_wrap();
    test_halt();
    test_timeout();
    test_done_at_timeout();
    test_reset_in_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
